// File: rtl/spi_txn_controller.sv
// Transaction-sequencing FSM for the SPI memory peripheral: counts address and
// data bits off the SCLK strobes and decodes the latch/load/write/buffer enables.
module spi_txn_controller #(
   parameter int unsigned ADDR_BITS = 7,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned CNT_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cs,
   input  logic             sclk_pos,
   input  logic             sclk_neg,
   input  logic             rw_bit,
   output logic             addr_we,
   output logic             sr_we,
   output logic             dm_we,
   output logic             buf_e,
   output logic             busy,
   output logic             done,
   output logic             abort,
   output logic [CNT_W-1:0] bit_count
);

   typedef enum logic [3:0] {
      IDLE,
      GET_ADDR,
      GOT_ADDR,
      READ_WAIT,
      READ_LOAD,
      READ_SHIFT,
      WRITE_SHIFT,
      WRITE_MEM,
      DONE
   } state_e;

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] bit_count_q, bit_count_d;
   logic             done_q, done_d;
   logic             abort_q, abort_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_count_q <= '0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_count_q <= bit_count_d;
         done_q      <= done_d;
         abort_q     <= abort_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_count_d = bit_count_q;
      abort_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!cs) begin
               state_d     = GET_ADDR;
               bit_count_d = '0;
            end
         end
         GET_ADDR: begin
            if (sclk_pos) begin
               if (bit_count_q == ADDR_LAST) begin
                  state_d     = GOT_ADDR;
                  bit_count_d = '0;
               end else begin
                  bit_count_d = bit_count_q + CNT_W'(1);
               end
            end
         end
         GOT_ADDR: begin
            state_d     = rw_bit ? READ_WAIT : WRITE_SHIFT;
            bit_count_d = '0;
         end
         READ_WAIT: state_d = READ_LOAD;
         READ_LOAD: state_d = READ_SHIFT;
         READ_SHIFT: begin
            if (sclk_neg) begin
               bit_count_d = bit_count_q + CNT_W'(1);
               if (bit_count_q == DATA_LAST) state_d = DONE;
            end
         end
         WRITE_SHIFT: begin
            if (sclk_pos) begin
               bit_count_d = bit_count_q + CNT_W'(1);
               if (bit_count_q == DATA_LAST) state_d = WRITE_MEM;
            end
         end
         WRITE_MEM: state_d = DONE;
         DONE: begin
            if (cs) state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            bit_count_d = '0;
         end
      endcase

      // cs release mid-transaction overrides any edge-driven move this cycle
      if (cs && (state_q != IDLE) && (state_q != DONE)) begin
         state_d     = IDLE;
         bit_count_d = '0;
         abort_d     = 1'b1;
      end

      done_d = (state_d == DONE) && (state_q != DONE);
   end

   always_comb begin
      addr_we   = (state_q == GOT_ADDR);
      sr_we     = (state_q == READ_LOAD);
      dm_we     = (state_q == WRITE_MEM);
      buf_e     = (state_q == READ_SHIFT);
      busy      = (state_q != IDLE);
      done      = done_q;
      abort     = abort_q;
      bit_count = bit_count_q;
   end

endmodule
